byte_write_sdpram: RTL and testbench

- Simple dual-port byte-write RAM: one write port and one independent read port, sharing one clock.
- Byte-addressed interface with per-byte write strobes.
- Read latency is parametrised (1..4 cycles) and tagged with a read-data-valid output.
- Serves as a matrix operand/result buffer: one engine streams writes while another streams reads.

---
 rtl/byte_write_sdpram.sv | 159 +++++++++++++++
 tb/tb_byte_write_sdpram.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_write_sdpram.sv
// byte_write_sdpram
// Simple dual-port RAM with one byte-strobed write port and one read port
// on a common clock. Addresses are byte addresses; the word index is taken
// from the bits just above the byte offset, so higher bits alias modulo
// ADDR_DEPTH. Reads pass through a READ_LATENCY-deep pipeline in which
// each stage carries its own valid bit.
//
// Optional feature: define BYTE_WRITE_SDPRAM_RD_WR_FWD_EN for write-first
// behaviour on a same-index read/write collision. This adds a per-byte
// merge of the write data ahead of stage 1. When the macro is undefined,
// a colliding read returns the pre-write word.

module byte_write_sdpram #(
    parameter int ADDR_DEPTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    input  logic [ADDR_WIDTH-1:0]     wr_address,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb,
    input  logic                      rd_valid,
    input  logic [ADDR_WIDTH-1:0]     rd_address,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_data_valid
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int ADDR_LSB  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 0;
    localparam int IDX_W     = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((DATA_WIDTH % 8) != 0) begin : g_chk_data_width
        $error("byte_write_sdpram: DATA_WIDTH must be a multiple of 8");
    end

    if ((ADDR_DEPTH < 2) || ((ADDR_DEPTH & (ADDR_DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("byte_write_sdpram: ADDR_DEPTH must be a power of two and at least 2");
    end

    if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_chk_latency
        $error("byte_write_sdpram: READ_LATENCY must be in the range 1..4");
    end

`ifdef BYTE_WRITE_SDPRAM_RD_WR_FWD_EN
    // Per-byte merge: strobed bytes come from new_word, the rest from old_word.
    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BYTES-1:0]  strb
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Storage and address decode
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   mem_q [ADDR_DEPTH];

    logic [IDX_W-1:0]        wr_idx_s;
    logic [IDX_W-1:0]        rd_idx_s;
    logic                    wr_en_s;
    logic                    rd_en_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic [DATA_WIDTH-1:0]   stage1_d;

    logic [DATA_WIDTH-1:0]   stage_data_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] stage_vld_q;
    logic [READ_LATENCY-1:0] stage_vld_d;

    // Byte offset and bits above the index are intentionally ignored.
    logic                    unused_addr_s;
    assign unused_addr_s = ^{wr_address, rd_address};

    assign wr_idx_s  = wr_address[ADDR_LSB +: IDX_W];
    assign rd_idx_s  = rd_address[ADDR_LSB +: IDX_W];

    // Requests presented during reset are discarded.
    assign wr_en_s   = wr_valid & ~rst;
    assign rd_en_s   = rd_valid & ~rst;

    assign rd_word_s = mem_q[rd_idx_s];

    // Byte-enable write into the array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx_s][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Value captured by stage 1: memory word, optionally merged with a colliding write.
    always_comb begin
        stage1_d = rd_word_s;
`ifdef BYTE_WRITE_SDPRAM_RD_WR_FWD_EN
        if (wr_valid && (wr_idx_s == rd_idx_s)) begin
            stage1_d = byte_merge(rd_word_s, wr_data, wr_strb);
        end else begin
            stage1_d = rd_word_s;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------

    // Valid bits shift one stage per cycle; stage 1 takes the new request.
    always_comb begin
        stage_vld_d    = '0;
        stage_vld_d[0] = rd_valid;
        for (int k = 1; k < READ_LATENCY; k++) begin
            stage_vld_d[k] = stage_vld_q[k-1];
        end
    end

    // Stage registers: reset clears valids and data, data loads only behind a valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                stage_data_q[k] <= '0;
            end
        end else begin
            stage_vld_q <= stage_vld_d;
            if (rd_en_s) begin
                stage_data_q[0] <= stage1_d;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                if (stage_vld_q[k-1]) begin
                    stage_data_q[k] <= stage_data_q[k-1];
                end
            end
        end
    end

    // The last stage drives the outputs directly and holds between results.
    assign rd_data       = stage_data_q[READ_LATENCY-1];
    assign rd_data_valid = stage_vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_byte_write_sdpram.sv
// Testbench for byte_write_sdpram. Three instances with READ_LATENCY 1, 2
// and 4 share one stimulus stream. A reference memory produces expected
// read words, which go into a scoreboard queue at issue time and are
// matched against each instance when its result is due.

module tb_byte_write_sdpram;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic [31:0] wr_address;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_valid;
    logic [31:0] rd_address;

    logic [31:0] rdd_s [3];
    logic [2:0]  rdv_s;

    int n_checks;
    int n_errors;
    int edge_cnt;

    typedef struct {
        logic [31:0] data;
        int          issue;
        logic [2:0]  live;
    } rd_t;

    rd_t         sb_q [$];
    logic [31:0] mem_m [32];
    logic [31:0] last_m [3];

    function automatic int lat_of(input int g);
        if (g == 0) return 1;
        else if (g == 1) return 2;
        else return 4;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        byte_write_sdpram #(
            .ADDR_DEPTH   (32),
            .ADDR_WIDTH   (32),
            .DATA_WIDTH   (32),
            .READ_LATENCY (L)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .wr_valid      (wr_valid),
            .wr_address    (wr_address),
            .wr_data       (wr_data),
            .wr_strb       (wr_strb),
            .rd_valid      (rd_valid),
            .rd_address    (rd_address),
            .rd_data       (rdd_s[g]),
            .rd_data_valid (rdv_s[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // One clock cycle: drive inputs, update the model at the edge, check all instances.
    task automatic cycle(input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] ws, input logic rv, input logic [31:0] ra,
                         input logic r);
        logic [31:0] rword;
        logic [4:0]  widx;
        logic [4:0]  ridx;
        logic        found;
        logic [31:0] exp;
        wr_valid   = wv;
        wr_address = wa;
        wr_data    = wd;
        wr_strb    = ws;
        rd_valid   = rv;
        rd_address = ra;
        rst        = r;
        @(posedge clk);
        edge_cnt++;
        widx = wa[6:2];
        ridx = ra[6:2];
        if (r) begin
            foreach (sb_q[i]) begin
                for (int g = 0; g < 3; g++) begin
                    if (sb_q[i].issue + lat_of(g) - 1 >= edge_cnt) sb_q[i].live[g] = 1'b0;
                end
            end
            for (int g = 0; g < 3; g++) last_m[g] = 32'h0;
        end else begin
            if (rv) begin
                rword = mem_m[ridx];
`ifdef BYTE_WRITE_SDPRAM_RD_WR_FWD_EN
                if (wv && (widx == ridx)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ws[b]) rword[8*b +: 8] = wd[8*b +: 8];
                    end
                end
`endif
                sb_q.push_back('{data: rword, issue: edge_cnt, live: 3'b111});
            end
            if (wv) begin
                for (int b = 0; b < 4; b++) begin
                    if (ws[b]) mem_m[widx][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
        #1;
        for (int g = 0; g < 3; g++) begin
            found = 1'b0;
            exp   = 32'h0;
            foreach (sb_q[i]) begin
                if (sb_q[i].live[g] && (sb_q[i].issue + lat_of(g) - 1 == edge_cnt)) begin
                    found = 1'b1;
                    exp   = sb_q[i].data;
                end
            end
            if (found) begin
                check_eq($sformatf("rd_data_valid L%0d", lat_of(g)), {31'h0, rdv_s[g]}, 32'h1);
                check_eq($sformatf("rd_data L%0d", lat_of(g)), rdd_s[g], exp);
                last_m[g] = exp;
            end else begin
                check_eq($sformatf("idle_valid L%0d", lat_of(g)), {31'h0, rdv_s[g]}, 32'h0);
                check_eq($sformatf("idle_hold L%0d", lat_of(g)), rdd_s[g], last_m[g]);
            end
        end
        while ((sb_q.size() > 0) && (sb_q[0].issue + 4 <= edge_cnt)) begin
            void'(sb_q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cycle(1'b1, a, d, s, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        edge_cnt = 0;
        for (int g = 0; g < 3; g++) last_m[g] = 32'h0;
        for (int i = 0; i < 32; i++) mem_m[i] = 32'hx;

        // Reset with requests present: all discarded, outputs zero.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h10, 1'b1);
        idle(4);

        // Latency: single write, idle, single read.
        wr(32'h10, 32'hA5A5_0001, 4'hF);
        idle(1);
        rd(32'h10);
        idle(5);

        // Byte strobes.
        wr(32'h14, 32'h1122_3344, 4'hF);
        wr(32'h14, 32'hAABB_CCDD, 4'b0101);
        rd(32'h14);
        idle(5);

        // Same-cycle collision.
        wr(32'h20, 32'h0000_0000, 4'hF);
        idle(1);
        cycle(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0011, 1'b1, 32'h20, 1'b0);
        idle(1);
        rd(32'h20);
        idle(5);

        // Back-to-back streaming plus alias.
        for (int i = 0; i < 32; i++) wr(32'(i * 4), 32'(i * 3), 4'hF);
        for (int i = 0; i < 32; i++) rd(32'(i * 4));
        rd(32'h80);
        idle(6);

        // Reset mid-flight, then a read after release.
        rd(32'h0C);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h10, 1'b1);
        idle(1);
        rd(32'h18);
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
